rr_arbiter_4: RTL and testbench

- Round-robin arbiter/scheduler sharing one resource among 4 requesters.
- Registered 2-bit winner index is expanded to a one-hot grant vector through an enabled 2-to-4 decoder.
- A grant is held until the owner drops its request or a hold-time limit expires.
- Sits between requester blocks and any shared datapath (bus, ALU, memory port) in the decoder/gate library.

---
 rtl/rr_arbiter_4_pkg.sv | 13 +
 rtl/rr_arbiter_4_if.sv | 21 ++
 rtl/rr_arbiter_4_dec_2_4_en.sv | 21 ++
 rtl/rr_arbiter_4.sv | 94 +++++++++
 tb/tb_rr_arbiter_4.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arbiter_4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NUM_REQ      = 4;
  localparam int IDX_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_id;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_id, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_arbiter_4_dec_2_4_en.sv
// Enabled 2-to-4 one-hot decoder; output is all zero when disabled.
module dec_2_4_en (
  input  logic       en,
  input  logic [1:0] i,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) begin
      case (i)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        2'd3:    y = 4'b1000;
        default: y = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with per-owner hold limit and a
// mandatory one-cycle idle gap between grants.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_4_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;
  logic               gnt_valid;
  logic               owner_req;
  logic               hold_expired;

  // First set request bit searching upward from p with 2-bit wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] idx;
    rr_pick = p;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = p + IDX_W'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign gnt_valid    = (state_q == BUSY);
  assign owner_req    = bus.req[gnt_id_q];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_id_d   = rr_pick(bus.req, ptr_q);
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req || hold_expired) begin
          state_d   = IDLE;
          ptr_d     = gnt_id_q + IDX_W'(1);
          timeout_d = owner_req;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          // Saturation only matters for MAX_HOLD=0; otherwise HOLD_LAST is hit first.
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout   = timeout_q;

  dec_2_4_en u_dec (
    .en (gnt_valid),
    .i  (gnt_id_q),
    .y  (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with MAX_HOLD = 8, 2 and 0 (unlimited).
module tb_rr_arbiter_4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  rr_arbiter_4_if a8();
  rr_arbiter_4_if a2();
  rr_arbiter_4_if a0();

  rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) u8 (.clk(clk), .rst(rst), .bus(a8.slave));
  rr_arbiter_4 #(.MAX_HOLD(2), .CNT_W(4)) u2 (.clk(clk), .rst(rst), .bus(a2.slave));
  rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(4)) u0 (.clk(clk), .rst(rst), .bus(a0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_rr [13];
    exp_rr = '{4'b0001, 4'b0001, 4'b0000,
               4'b0010, 4'b0010, 4'b0000,
               4'b0100, 4'b0100, 4'b0000,
               4'b1000, 4'b1000, 4'b0000,
               4'b0001};
    n_checks = 0;
    n_err    = 0;
    rst    = 1'b1;
    a8.req = 4'b0000;
    a2.req = 4'b0000;
    a0.req = 4'b0000;
    tick();
    tick();

    chk("rst_gnt8", a8.gnt, 4'b0000);
    chk("rst_vld8", a8.gnt_valid, 1'b0);
    chk("rst_to8",  a8.timeout, 1'b0);
    chk("rst_gnt2", a2.gnt, 4'b0000);
    chk("rst_vld2", a2.gnt_valid, 1'b0);
    chk("rst_gnt0", a0.gnt, 4'b0000);
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("idle_gnt_%0d", c), a8.gnt, 4'b0000);
      chk($sformatf("idle_vld_%0d", c), a8.gnt_valid, 1'b0);
      chk($sformatf("idle_to_%0d", c),  a8.timeout, 1'b0);
    end

    // Single requester 2, held for four edges then dropped.
    a8.req = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("single_gnt_%0d", c), a8.gnt, 4'b0100);
      chk($sformatf("single_id_%0d", c),  a8.gnt_id, 2'd2);
    end
    a8.req = 4'b0000;
    tick();
    chk("single_rel_gnt", a8.gnt, 4'b0000);
    chk("single_rel_vld", a8.gnt_valid, 1'b0);

    // ptr is now 3: between requesters 2 and 3, 3 wins.
    a8.req = 4'b1100;
    tick();
    chk("ptr3_gnt", a8.gnt, 4'b1000);
    chk("ptr3_id",  a8.gnt_id, 2'd3);

    a8.req = 4'b1001;
    tick();
    chk("hold3_gnt", a8.gnt, 4'b1000);

    // Reset in the middle of a grant; ptr returns to 0.
    rst = 1'b1;
    tick();
    chk("midrst_gnt", a8.gnt, 4'b0000);
    chk("midrst_vld", a8.gnt_valid, 1'b0);
    chk("midrst_to",  a8.timeout, 1'b0);
    rst = 1'b0;
    tick();
    chk("postrst_gnt", a8.gnt, 4'b0001);
    chk("postrst_id",  a8.gnt_id, 2'd0);
    a8.req = 4'b0000;
    tick();
    chk("postrst_rel", a8.gnt, 4'b0000);

    // Requester 1 alone hits the 8-cycle hold limit.
    a8.req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("hold8_gnt_%0d", c), a8.gnt, 4'b0010);
      chk($sformatf("hold8_to_%0d", c),  a8.timeout, 1'b0);
    end
    tick();
    chk("to8_gnt", a8.gnt, 4'b0000);
    chk("to8_vld", a8.gnt_valid, 1'b0);
    chk("to8_to",  a8.timeout, 1'b1);
    tick();
    chk("regrant8_gnt", a8.gnt, 4'b0010);
    chk("regrant8_to",  a8.timeout, 1'b0);
    a8.req = 4'b0000;
    tick();
    chk("rel1_gnt", a8.gnt, 4'b0000);
    chk("rel1_to",  a8.timeout, 1'b0);

    // ptr is 2 after requester 1 released: search 2,3,0 picks 0.
    a8.req = 4'b0011;
    tick();
    chk("ptr2_gnt", a8.gnt, 4'b0001);
    chk("ptr2_id",  a8.gnt_id, 2'd0);
    a8.req = 4'b0000;
    tick();

    // All four requesting with MAX_HOLD=2: rotation with timeout gaps.
    a2.req = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      tick();
      chk($sformatf("rr_gnt_%0d", k), a2.gnt, exp_rr[k]);
      chk($sformatf("rr_to_%0d", k),  a2.timeout, (k % 3 == 2) ? 1'b1 : 1'b0);
    end
    a2.req = 4'b0000;
    tick();

    // MAX_HOLD=0: grant held indefinitely, past counter saturation.
    a0.req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("unl_gnt_%0d", c), a0.gnt, 4'b0001);
      chk($sformatf("unl_to_%0d", c),  a0.timeout, 1'b0);
    end
    a0.req = 4'b0000;
    tick();
    chk("unl_rel_gnt", a0.gnt, 4'b0000);
    chk("unl_rel_vld", a0.gnt_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
